// File: rtl/cpu_memory_access.sv
// -----------------------------------------------------------------------------
// cpu_memory_access
//
// Memory-access pipeline stage placed right after execute. A one-cycle
// load/store command is captured, run on the data-memory bus with a
// request/acknowledge handshake, and the pipeline is stalled until the bus
// completes. Loads return byte-lane-extracted data to the register-file write
// port. An unresponsive bus is converted into a sticky bus_error after
// TIMEOUT_CYCLES request cycles.
//
// Ports:
//   CLK, RSTb            clock; synchronous active-low reset
//   load_memory          one-cycle load command from execute
//   store_memory         one-cycle store command from execute (wins over load)
//   byte_op              command is a byte access
//   load_store_address   byte address
//   memory_out           store data, already lane-aligned by execute
//   memory_wr_mask       byte-lane mask (bit1 = [15:8], bit0 = [7:0])
//   dest_reg             load destination register
//   mem_req/mem_wr/mem_addr/mem_wdata/mem_wmask   bus request side
//   mem_ack/mem_rdata    bus completion; rdata valid with ack
//   stall                pipeline hold (state != IDLE)
//   wb_valid/wb_reg/wb_data   one-cycle register write-back
//   bus_error            sticky timeout flag, cleared only by reset
//
// Handshake: mem_req is held high with mem_addr/mem_wr/mem_wdata/mem_wmask
// stable from the first REQ cycle until the cycle in which mem_ack is high;
// that cycle completes the transfer (read data is taken from mem_rdata in the
// same cycle) and mem_req is low from the next cycle. mem_ack outside a
// request is ignored. Upstream must not present a command while stall is high.
// -----------------------------------------------------------------------------
module cpu_memory_access #(
  parameter int BITS           = 16,
  parameter int ADDRESS_BITS   = 16,
  parameter int REGISTER_BITS  = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      CLK,
  input  logic                      RSTb,
  input  logic                      load_memory,
  input  logic                      store_memory,
  input  logic                      byte_op,
  input  logic [ADDRESS_BITS-1:0]   load_store_address,
  input  logic [BITS-1:0]           memory_out,
  input  logic [1:0]                memory_wr_mask,
  input  logic [REGISTER_BITS-1:0]  dest_reg,
  output logic                      mem_req,
  output logic                      mem_wr,
  output logic [ADDRESS_BITS-2:0]   mem_addr,
  output logic [BITS-1:0]           mem_wdata,
  output logic [1:0]                mem_wmask,
  input  logic                      mem_ack,
  input  logic [BITS-1:0]           mem_rdata,
  output logic                      stall,
  output logic                      wb_valid,
  output logic [REGISTER_BITS-1:0]  wb_reg,
  output logic [BITS-1:0]           wb_data,
  output logic                      bus_error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WB   = 2'd2
  } state_t;

  // Counter value in the last allowed request cycle without ack.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                     state_q, state_d;
  logic [7:0]                 wait_cnt_q, wait_cnt_d;
  logic [ADDRESS_BITS-1:0]    addr_q, addr_d;
  logic [BITS-1:0]            wdata_q, wdata_d;
  logic [1:0]                 mask_q, mask_d;
  logic                       byte_q, byte_d;
  logic                       wr_q, wr_d;
  logic [REGISTER_BITS-1:0]   dest_q, dest_d;
  logic [REGISTER_BITS-1:0]   wb_reg_q, wb_reg_d;
  logic [BITS-1:0]            wb_data_q, wb_data_d;
  logic                       bus_error_q, bus_error_d;
  logic [BITS-1:0]            load_data;

  // Byte loads pick the lane selected by the latched address bit 0 and
  // zero-extend it; word loads pass the bus data through.
  always_comb begin
    load_data = mem_rdata;
    if (byte_q) begin
      if (addr_q[0]) begin
        load_data = {{(BITS-8){1'b0}}, mem_rdata[15:8]};
      end else begin
        load_data = {{(BITS-8){1'b0}}, mem_rdata[7:0]};
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mask_d      = mask_q;
    byte_d      = byte_q;
    wr_d        = wr_q;
    dest_d      = dest_q;
    wb_reg_d    = wb_reg_q;
    wb_data_d   = wb_data_q;
    bus_error_d = bus_error_q;

    case (state_q)
      IDLE: begin
        wait_cnt_d = '0;
        if (store_memory || load_memory) begin
          addr_d  = load_store_address;
          wdata_d = memory_out;
          mask_d  = memory_wr_mask;
          byte_d  = byte_op;
          dest_d  = dest_reg;
          wr_d    = store_memory;  // store wins when both are high
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_ack) begin
          wait_cnt_d = '0;
          if (wr_q) begin
            state_d = IDLE;
          end else begin
            wb_data_d = load_data;
            wb_reg_d  = dest_q;
            state_d   = WB;
          end
        end else if (wait_cnt_q == TIMEOUT_LAST) begin
          // Give up on the bus: flag it and abandon the access.
          bus_error_d = 1'b1;
          wait_cnt_d  = '0;
          state_d     = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      WB: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      byte_q      <= 1'b0;
      wr_q        <= 1'b0;
      dest_q      <= '0;
      wb_reg_q    <= '0;
      wb_data_q   <= '0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
      byte_q      <= byte_d;
      wr_q        <= wr_d;
      dest_q      <= dest_d;
      wb_reg_q    <= wb_reg_d;
      wb_data_q   <= wb_data_d;
      bus_error_q <= bus_error_d;
    end
  end

  // Bus outputs are decoded from registered state and forced to zero outside
  // REQ so the bus sees a clean idle value.
  assign mem_req   = (state_q == REQ);
  assign mem_wr    = mem_req & wr_q;
  assign mem_addr  = mem_req ? addr_q[ADDRESS_BITS-1:1] : '0;
  assign mem_wdata = mem_wr ? wdata_q : '0;
  assign mem_wmask = mem_req ? mask_q : 2'b00;

  assign stall     = (state_q != IDLE);
  assign wb_valid  = (state_q == WB);
  assign wb_reg    = wb_reg_q;
  assign wb_data   = wb_data_q;
  assign bus_error = bus_error_q;

endmodule

// File: doc/cpu_memory_access.md
# cpu_memory_access

Memory-access pipeline stage that sits directly downstream of the execute stage. It captures the single-cycle load/store command produced by execute, runs it on the data-memory bus with a request/acknowledge handshake, and stalls the pipeline while the bus is busy. For loads it extracts byte lanes and returns the result to the register-file write port. A bounded wait counter turns an unresponsive bus into a sticky error instead of a hang.

## Interface
- BITS, 16, data width
- ADDRESS_BITS, 16, byte address width
- REGISTER_BITS, 4, register index width
- TIMEOUT_CYCLES, 255, maximum cycles to wait for mem_ack (1..255)

- CLK  in  1  clock
- RSTb  in  1  reset; synchronous, active-low
- load_memory  in  1  load command from execute (one-cycle)
- store_memory  in  1  store command from execute (one-cycle)
- byte_op  in  1  command is a byte load/store
- load_store_address  in  ADDRESS_BITS  byte address
- memory_out  in  BITS  store data, already lane-aligned by execute
- memory_wr_mask  in  2  byte-lane mask (bit1 = [15:8], bit0 = [7:0])
- dest_reg  in  REGISTER_BITS  load destination register
- mem_req  out  1  bus request
- mem_wr  out  1  1 = write, 0 = read; valid while mem_req
- mem_addr  out  ADDRESS_BITS-1  word address = load_store_address[ADDRESS_BITS-1:1]
- mem_wdata  out  BITS  write data
- mem_wmask  out  2  write lane mask
- mem_ack  in  1  bus completion; read data valid in the same cycle
- mem_rdata  in  BITS  read data
- stall  out  1  pipeline hold
- wb_valid  out  1  one-cycle register write strobe
- wb_reg  out  REGISTER_BITS  write-back register index
- wb_data  out  BITS  write-back data
- bus_error  out  1  sticky timeout flag

## Operation
- FSM states: IDLE, REQ, WB.
- IDLE
  - If store_memory or load_memory is high, latch address, data, mask, byte_op, address bit 0, dest_reg and a direction bit, then go to REQ.
  - Store wins if both are high; the load is dropped.
- REQ
  - mem_req = 1. mem_addr, mem_wr, mem_wdata and mem_wmask are driven from the latched values and stay stable until ack.
  - Wait counter increments each cycle without mem_ack.
  - On mem_ack with a store, go to IDLE.
  - On mem_ack with a load, register the result into wb_data and go to WB.
  - If the counter reaches TIMEOUT_CYCLES with no ack: set bus_error, drop the request, go to IDLE. No write-back occurs.
- WB: wb_valid = 1 for exactly one cycle, then go to IDLE.
- Load data rules:
  - Word load: wb_data = mem_rdata.
  - Byte load, address bit 0 = 0: wb_data = {8'h00, mem_rdata[7:0]}.
  - Byte load, address bit 0 = 1: wb_data = {8'h00, mem_rdata[15:8]}.
- Store side: mem_wmask is the latched memory_wr_mask. Word stores drive 2'b11 from execute. No re-alignment is done here.
- Outside REQ: mem_wr and mem_wdata are 0. Outside WB: wb_reg and wb_data hold their last values, and wb_valid is 0.
- stall = (state != IDLE), decoded from registered state.
  - Upstream must not present a new command while stall is high.
  - Commands arriving in REQ or WB are ignored.
- bus_error clears only on reset.

## Timing
- Reset values: state IDLE, counter 0, and all outputs 0 (mem_req, mem_wr, mem_addr, mem_wdata, mem_wmask, stall, wb_valid, wb_reg, wb_data, bus_error).
- Command sampled at edge 0 → mem_req and stall high in cycle 1.
- mem_ack in cycle k:
  - Store: mem_req low and stall low from cycle k+1.
  - Load: wb_valid in cycle k+1, stall low from cycle k+2.
- Minimum latency (ack in cycle 1): store occupies 1 stall cycle; load occupies 2, with write-back in cycle 2.
- Timeout: with no ack, mem_req stays high for TIMEOUT_CYCLES cycles. bus_error rises and mem_req falls on the following edge.
- mem_ack outside REQ is ignored.
- Reset asserted mid-operation: at the reset edge the state returns to IDLE, mem_req drops, and no pending write-back is issued.
- Back-to-back: a command presented in the first cycle with stall low is accepted.

## Test plan
- Word store to 0x1234 with data 0xBEEF and ack in cycle 1 → mem_addr 0x091A, mem_wr 1, mask 2'b11, stall high for 1 cycle, no wb_valid.
- Word load from 0x0040 to r5, ack after 3 wait cycles with rdata 0xA55A → mem_req high for 4 cycles, wb_valid one cycle with wb_reg 5 and wb_data 0xA55A.
- Byte loads from 0x0101 and 0x0100 with rdata 0x12AB → wb_data 0x0012 and 0x00AB respectively.
- load_memory and store_memory both high → store performed, no wb_valid; a second command during stall is ignored.
- No ack with TIMEOUT_CYCLES = 4 → mem_req high for 4 cycles, then bus_error 1, IDLE, no write-back; bus_error persists until RSTb is low.
- RSTb low during REQ of a load → next cycle mem_req 0, stall 0, wb_valid never asserted; a late mem_ack is ignored.
